// File: rtl/muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// muldiv_ctrl
//   Multiply/divide unit controller with architectural HI/LO registers.
//   mult/multu/div/divu compute their result in the accepting cycle and park
//   it in shadow registers.  A busy window of MULT_CYCLES or DIV_CYCLES then
//   models the unit latency before the result is committed to HI/LO.
//   mthi/mtlo write HI/LO directly, with no busy window.
//
// Ports
//   clk      in   1   clock, rising edge
//   reset    in   1   asynchronous, active-high reset
//   start    in   1   E-stage muldiv instruction valid
//   op       in   3   1=mult 2=multu 3=div 4=divu 5=mthi 6=mtlo, else no-op
//   a        in  32   rs operand
//   b        in  32   rt operand
//   cancel   in   1   pipeline flush, kills a same-cycle start only
//   out_sel  in   1   0 selects HI, 1 selects LO onto dout
//   busy     out  1   multi-cycle operation in progress
//   dout     out 32   selected HI or LO
//   hi       out 32   architectural HI
//   lo       out 32   architectural LO
// ---------------------------------------------------------------------------
module muldiv_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  input  logic        out_sel,
  output logic        busy,
  output logic [31:0] dout,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] res_hi_q, res_hi_d;
  logic [31:0] res_lo_q, res_lo_d;

  logic        accept_s;
  logic [63:0] prod_s_s;
  logic [63:0] prod_u_s;
  logic [31:0] abs_a_s;
  logic [31:0] abs_b_s;
  logic [31:0] sdiv_den_s;
  logic [31:0] udiv_den_s;
  logic [31:0] mag_q_s;
  logic [31:0] mag_r_s;
  logic [31:0] squot_s;
  logic [31:0] srem_s;
  logic [31:0] uquot_s;
  logic [31:0] urem_s;

  assign accept_s = (state_q == IDLE) && start && !cancel &&
                    (op >= 3'd1) && (op <= 3'd6);

  // Signed product: sign-extend to 64 bits; the low 64 bits of the
  // unsigned product are the two's-complement signed product.
  assign prod_s_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u_s = {32'd0, a} * {32'd0, b};

  // Signed divide through magnitudes.  0x80000000 is its own magnitude as an
  // unsigned value, so 0x80000000 / -1 naturally yields lo=0x80000000, hi=0.
  // A zero divisor is replaced by 1 only to keep the divider defined; that
  // result is never committed.
  assign abs_a_s    = a[31] ? (~a + 32'd1) : a;
  assign abs_b_s    = b[31] ? (~b + 32'd1) : b;
  assign sdiv_den_s = (abs_b_s == 32'd0) ? 32'd1 : abs_b_s;
  assign mag_q_s    = abs_a_s / sdiv_den_s;
  assign mag_r_s    = abs_a_s % sdiv_den_s;
  assign squot_s    = (a[31] ^ b[31]) ? (~mag_q_s + 32'd1) : mag_q_s;
  assign srem_s     = a[31] ? (~mag_r_s + 32'd1) : mag_r_s;

  assign udiv_den_s = (b == 32'd0) ? 32'd1 : b;
  assign uquot_s    = a / udiv_den_s;
  assign urem_s     = a % udiv_den_s;

  // Next-state logic: acceptance in IDLE, countdown and commit in BUSY.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          case (op)
            3'd1: begin
              res_hi_d = prod_s_s[63:32];
              res_lo_d = prod_s_s[31:0];
              cnt_d    = MULT_CNT;
              state_d  = BUSY;
            end
            3'd2: begin
              res_hi_d = prod_u_s[63:32];
              res_lo_d = prod_u_s[31:0];
              cnt_d    = MULT_CNT;
              state_d  = BUSY;
            end
            3'd3: begin
              // Divide by zero re-commits the current HI/LO, which cannot
              // change while BUSY, so the registers end up untouched.
              res_hi_d = (b == 32'd0) ? hi_q : srem_s;
              res_lo_d = (b == 32'd0) ? lo_q : squot_s;
              cnt_d    = DIV_CNT;
              state_d  = BUSY;
            end
            3'd4: begin
              res_hi_d = (b == 32'd0) ? hi_q : urem_s;
              res_lo_d = (b == 32'd0) ? lo_q : uquot_s;
              cnt_d    = DIV_CNT;
              state_d  = BUSY;
            end
            3'd5: begin
              hi_d = a;
            end
            3'd6: begin
              lo_d = a;
            end
            default: begin
              state_d = IDLE;
            end
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        // start and cancel are ignored here: the running operation belongs
        // to an older instruction and always completes.
        if (cnt_q == 4'd1) begin
          hi_d    = res_hi_q;
          lo_d    = res_lo_q;
          cnt_d   = 4'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State and data registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
    end
  end

  assign busy = (state_q == BUSY);
  assign hi   = hi_q;
  assign lo   = lo_q;
  assign dout = out_sel ? lo_q : hi_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        out_sel;
  logic        busy;
  logic [31:0] dout;
  logic [31:0] hi;
  logic [31:0] lo;

  muldiv_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .out_sel(out_sel), .busy(busy), .dout(dout),
    .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [31:0] cur_hi = 32'd0;
  logic [31:0] cur_lo = 32'd0;
  int          busy_len = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference model: architectural effect of one accepted op.
  task automatic model_apply(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                             inout logic [31:0] h, inout logic [31:0] l, output int cyc);
    longint      sa;
    longint      sb;
    longint      p;
    longint      qv;
    longint      rv;
    logic [63:0] pu;
    sa  = $signed(av);
    sb  = $signed(bv);
    cyc = 0;
    case (o)
      3'd1: begin p = sa * sb; h = p[63:32]; l = p[31:0]; cyc = MC; end
      3'd2: begin pu = {32'd0, av} * {32'd0, bv}; h = pu[63:32]; l = pu[31:0]; cyc = MC; end
      3'd3: begin
        if (bv != 32'd0) begin qv = sa / sb; rv = sa % sb; l = qv[31:0]; h = rv[31:0]; end
        cyc = DC;
      end
      3'd4: begin
        if (bv != 32'd0) begin l = av / bv; h = av % bv; end
        cyc = DC;
      end
      3'd5: h = av;
      3'd6: l = av;
      default: cyc = 0;
    endcase
  endtask

  // Issue one instruction (DUT idle, called at posedge+1), push the expected
  // outcome, then ride out any busy window with random noise on the inputs.
  task automatic run_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input logic cv, input logic use_fix, input logic [31:0] fhi,
                        input logic [31:0] flo, input int cancel_at);
    int   cyc;
    logic done;
    exp_t e;
    start = 1'b1; op = o; a = av; b = bv; cancel = cv;
    out_sel = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
    cyc = 0;
    if (!cv && o >= 3'd1 && o <= 3'd6) begin
      model_apply(o, av, bv, m_hi, m_lo, cyc);
      if (use_fix) begin m_hi = fhi; m_lo = flo; end
    end
    e.hi = m_hi; e.lo = m_lo; e.cyc = cyc;
    sb_q.push_back(e);
    if (cyc > 0) begin
      done = 1'b0;
      for (int k = 1; k <= 40; k++) begin
        if (!busy) begin done = 1'b1; break; end
        start   = 1'($urandom_range(0, 1));
        op      = 3'($urandom_range(0, 7));
        a       = $urandom;
        b       = $urandom;
        cancel  = (k == cancel_at) ? 1'b1 : 1'($urandom_range(0, 1));
        out_sel = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      start = 1'b0; cancel = 1'b0;
      if (!done) begin
        n_cmp++; n_err++;
        $display("FAIL busy_timeout: busy still %b after 40 cycles, expected 0", busy);
      end
    end
  endtask

  // Monitor: checks HI/LO hold during busy, pops an expectation whenever the
  // unit is idle, and measures the busy window length.
  always @(negedge clk) begin
    exp_t e;
    if (reset) busy_len = 0;
    if (busy) begin
      busy_len++;
      check("hold_hi", hi, cur_hi);
      check("hold_lo", lo, cur_lo);
    end else if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("hi", hi, e.hi);
      check("lo", lo, e.lo);
      check("dout", dout, out_sel ? e.lo : e.hi);
      check("busy_cycles", 32'(busy_len), 32'(e.cyc));
      cur_hi   = e.hi;
      cur_lo   = e.lo;
      busy_len = 0;
    end else if (busy_len != 0) begin
      n_cmp++; n_err++;
      $display("FAIL spurious_busy: got %0d busy cycles, expected 0", busy_len);
      busy_len = 0;
    end
  end

  initial begin
    exp_t     e;
    logic [2:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    reset = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
    cancel = 1'b0; out_sel = 1'b0;
    e.hi = 32'd0; e.lo = 32'd0; e.cyc = 0;
    sb_q.push_back(e);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Directed cases with expected values written out explicitly.
    run_op(3'd1, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA, 0);
    run_op(3'd2, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b1, 32'h00000002, 32'hFFFFFFFA, 0);
    run_op(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    run_op(3'd4, 32'd7, 32'd2, 1'b0, 1'b1, 32'd1, 32'd3, 0);
    run_op(3'd5, 32'h12345678, 32'd0, 1'b0, 1'b1, 32'h12345678, 32'd3, 0);
    run_op(3'd6, 32'h9ABCDEF0, 32'd0, 1'b0, 1'b1, 32'h12345678, 32'h9ABCDEF0, 0);
    run_op(3'd5, 32'h000000AA, 32'd0, 1'b0, 1'b1, 32'h000000AA, 32'h9ABCDEF0, 0);
    run_op(3'd6, 32'h000000BB, 32'd0, 1'b0, 1'b1, 32'h000000AA, 32'h000000BB, 0);
    run_op(3'd3, 32'h12345678, 32'd0, 1'b0, 1'b1, 32'h000000AA, 32'h000000BB, 0);
    run_op(3'd4, 32'h12345678, 32'd0, 1'b0, 1'b1, 32'h000000AA, 32'h000000BB, 0);
    run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1, 32'd0, 32'h80000000, 0);
    run_op(3'd1, 32'd100, 32'd100, 1'b1, 1'b1, 32'd0, 32'h80000000, 0);
    run_op(3'd1, 32'd100, 32'd100, 1'b0, 1'b1, 32'd0, 32'd10000, 2);

    // Reset on the 3rd busy cycle of a div aborts it.
    start = 1'b1; op = 3'd3; a = 32'd1000; b = 32'd7; cancel = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    m_hi = 32'd0; m_lo = 32'd0;
    e.hi = 32'd0; e.lo = 32'd0; e.cyc = 0;
    sb_q.push_back(e);
    @(posedge clk); #1;
    reset = 1'b0;
    run_op(3'd1, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA, 0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFFFFFF;
        2:       rb = $urandom_range(1, 9);
        default: rb = $urandom;
      endcase
      run_op(ro, ra, rb, ($urandom_range(0, 7) == 0), 1'b0, 32'd0, 32'd0, 0);
    end

    for (int k = 0; k < 50 && sb_q.size() != 0; k++) @(negedge clk);
    if (sb_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain: got %0d pending expectations, expected 0", sb_q.size());
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
